// File: rtl/nco_timekeeper.sv
// nco_timekeeper
//   Time-of-day counter driven by a numerically controlled tick.
//   An up-counter (cnt) produces a one-cycle tick every max(num,1)
//   clocks while in RUN. Each tick advances the sec/min/hour cascade.
//   A four-state mode FSM lets the user set each field with push-button
//   pulses that are already debounced upstream.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   RUN      | NCO counts, ticks advance the time cascade
//   SET_HOUR | NCO held at 0, inc_btn bumps hour mod HOUR_MOD
//   SET_MIN  | NCO held at 0, inc_btn bumps min mod 60
//   SET_SEC  | NCO held at 0, inc_btn bumps sec mod 60
//
// Ports
//   clk, rst_n       system clock, async active-low reset
//   num              divide ratio (0 and 1 both mean a tick every cycle)
//   clr              synchronous clear of time and NCO (state kept)
//   mode_btn         advances RUN->SET_HOUR->SET_MIN->SET_SEC->RUN
//   inc_btn          increments the selected field in SET states
//   sec, min, hour   current time
//   state            current mode (0..3 as in the table above)
//   tick             high when the counters show a tick-produced value
//   day_wrap         high when the time has just wrapped to 0:00:00
module nco_timekeeper #(
  parameter int NUM_W    = 32,
  parameter int HOUR_MOD = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_W-1:0] num,
  input  logic             clr,
  input  logic             mode_btn,
  input  logic             inc_btn,
  output logic [5:0]       sec,
  output logic [5:0]       min,
  output logic [4:0]       hour,
  output logic [1:0]       state,
  output logic             tick,
  output logic             day_wrap
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

  localparam logic [4:0]       HOUR_LAST = 5'(HOUR_MOD - 1);
  localparam logic [NUM_W-1:0] ONE       = NUM_W'(1);

  state_e           state_q, state_d;
  logic [NUM_W-1:0] cnt_q, cnt_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             tick_q, tick_d;
  logic             day_wrap_q, day_wrap_d;

  logic [NUM_W-1:0] num_m1;
  logic             tick_edge;
  logic             sec_last, min_last, hour_last;
  logic [5:0]       sec_inc, min_inc;
  logic [4:0]       hour_inc;

  // num=0 is folded onto num=1 so the terminal count never underflows.
  // Using >= also makes a freshly lowered num take effect on the next edge.
  assign num_m1    = (num == '0) ? '0 : num - ONE;
  assign tick_edge = (state_q == RUN) && (cnt_q >= num_m1);

  assign sec_last  = (sec_q == 6'd59);
  assign min_last  = (min_q == 6'd59);
  assign hour_last = (hour_q == HOUR_LAST);
  assign sec_inc   = sec_last  ? 6'd0 : sec_q + 6'd1;
  assign min_inc   = min_last  ? 6'd0 : min_q + 6'd1;
  assign hour_inc  = hour_last ? 5'd0 : hour_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    tick_d     = 1'b0;
    day_wrap_d = 1'b0;

    if (clr) begin
      cnt_d  = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (mode_btn) begin
      // Any mode change leaves the NCO at 0: leaving RUN clears it, and
      // the SET states already hold it there.
      cnt_d = '0;
      unique case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        SET_SEC:  state_d = RUN;
        default:  state_d = RUN;
      endcase
    end else if (state_q == RUN) begin
      if (tick_edge) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sec_d  = sec_inc;
        if (sec_last) begin
          min_d = min_inc;
          if (min_last) begin
            hour_d     = hour_inc;
            day_wrap_d = hour_last;
          end
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = '0;
      if (inc_btn) begin
        unique case (state_q)
          SET_HOUR: hour_d = hour_inc;
          SET_MIN:  min_d  = min_inc;
          SET_SEC:  sec_d  = sec_inc;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      tick_q     <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      tick_q     <= tick_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign sec      = sec_q;
  assign min      = min_q;
  assign hour     = hour_q;
  assign state    = state_q;
  assign tick     = tick_q;
  assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_nco_timekeeper.sv
// Directed bench for nco_timekeeper. A 24-hour and a 12-hour instance
// share all inputs; the 12-hour one is checked where hours differ.
module tb_nco_timekeeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] num;
  logic        clr, mode_btn, inc_btn;

  logic [5:0]  sec, min, e_sec, e_min;
  logic [4:0]  hour, e_hour;
  logic [1:0]  state, e_state;
  logic        tick, day_wrap, e_tick, e_day_wrap;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nco_timekeeper #(.NUM_W(32), .HOUR_MOD(24)) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .clr(clr),
    .mode_btn(mode_btn), .inc_btn(inc_btn),
    .sec(sec), .min(min), .hour(hour), .state(state),
    .tick(tick), .day_wrap(day_wrap)
  );

  nco_timekeeper #(.NUM_W(32), .HOUR_MOD(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .num(num), .clr(clr),
    .mode_btn(mode_btn), .inc_btn(inc_btn),
    .sec(e_sec), .min(e_min), .hour(e_hour), .state(e_state),
    .tick(e_tick), .day_wrap(e_day_wrap)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      inc_btn = 1'b1;
      step();
    end
    inc_btn = 1'b0;
  endtask

  task automatic check_time(input string tag, input int h, input int m,
                            input int s);
    check_val({tag, ".hour"}, 32'(hour), 32'(h));
    check_val({tag, ".min"},  32'(min),  32'(m));
    check_val({tag, ".sec"},  32'(sec),  32'(s));
  endtask

  initial begin
    int ticks;
    rst_n = 1'b0; num = 32'd5; clr = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;

    // reset state
    step(); step();
    check_time("rst", 0, 0, 0);
    check_val("rst.state", 32'(state), 0);
    check_val("rst.tick", 32'(tick), 0);
    check_val("rst.day_wrap", 32'(day_wrap), 0);
    rst_n = 1'b1;

    // num=5: tick on edges 5,10,..,25
    for (int e = 1; e <= 25; e++) begin
      step();
      check_val($sformatf("n5.tick%0d", e), 32'(tick), (e % 5 == 0) ? 1 : 0);
      check_val($sformatf("n5.sec%0d", e), 32'(sec), 32'(e / 5));
    end

    // preload 23:59:58 (12h instance: 11:59:58)
    press_mode();
    check_val("set.state_h", 32'(state), 1);
    press_inc(23);
    check_val("set.hour", 32'(hour), 23);
    check_val("set.hour12", 32'(e_hour), 11);
    press_mode();
    check_val("set.state_m", 32'(state), 2);
    press_inc(59);
    check_val("set.min59", 32'(min), 59);
    press_inc(1);
    check_val("set.min_wrap", 32'(min), 0);
    check_val("set.min_wrap_hour", 32'(hour), 23);
    check_val("set.min_wrap_dw", 32'(day_wrap), 0);
    press_inc(59);
    mode_btn = 1'b1; inc_btn = 1'b1;
    step();
    mode_btn = 1'b0; inc_btn = 1'b0;
    check_val("set.both_state", 32'(state), 3);
    check_val("set.both_min", 32'(min), 59);
    press_inc(53);
    check_val("set.sec", 32'(sec), 58);
    num = 32'd2;
    press_mode();
    check_val("set.state_run", 32'(state), 0);

    // num=2 from 23:59:58: ticks on edges 2 and 4, wrap on edge 4
    step();
    check_val("wrap.e1.tick", 32'(tick), 0);
    step();
    check_val("wrap.e2.tick", 32'(tick), 1);
    check_time("wrap.e2", 23, 59, 59);
    check_val("wrap.e2.hour12", 32'(e_hour), 11);
    check_val("wrap.e2.dw", 32'(day_wrap), 0);
    step();
    check_val("wrap.e3.tick", 32'(tick), 0);
    step();
    check_val("wrap.e4.tick", 32'(tick), 1);
    check_val("wrap.e4.dw", 32'(day_wrap), 1);
    check_time("wrap.e4", 0, 0, 0);
    check_val("wrap.e4.hour12", 32'(e_hour), 0);
    check_val("wrap.e4.dw12", 32'(e_day_wrap), 1);
    step();
    check_val("wrap.e5.dw", 32'(day_wrap), 0);
    check_val("wrap.e5.dw12", 32'(e_day_wrap), 0);
    check_val("wrap.e5.tick", 32'(tick), 0);

    // num=100 until cnt=80, then lower to 10
    num = 32'd100;
    ticks = 0;
    for (int e = 0; e < 79; e++) begin
      step();
      if (tick) ticks++;
    end
    check_val("n100.no_ticks", 32'(ticks), 0);
    num = 32'd10;
    step();
    check_val("n10.first_tick", 32'(tick), 1);
    check_val("n10.sec1", 32'(sec), 1);
    ticks = 0;
    for (int e = 0; e < 9; e++) begin
      step();
      if (tick) ticks++;
    end
    check_val("n10.gap", 32'(ticks), 0);
    step();
    check_val("n10.second_tick", 32'(tick), 1);
    check_val("n10.sec2", 32'(sec), 2);

    // num=0: tick every cycle
    num = 32'd0;
    for (int e = 1; e <= 5; e++) begin
      step();
      check_val($sformatf("n0.tick%0d", e), 32'(tick), 1);
      check_val($sformatf("n0.sec%0d", e), 32'(sec), 32'(2 + e));
    end
    for (int e = 0; e < 52; e++) step();
    check_time("n0.pre_clr", 0, 0, 59);

    // clr coincident with a tick at 00:00:59
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_time("clr.tick", 0, 0, 0);
    check_val("clr.tick_low", 32'(tick), 0);

    // mode_btn beats a coincident tick
    press_mode();
    check_val("mode_tick.state", 32'(state), 1);
    check_val("mode_tick.sec", 32'(sec), 0);
    check_val("mode_tick.tick", 32'(tick), 0);
    press_mode();
    press_inc(3);
    check_val("clr_set.min3", 32'(min), 3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_val("clr_set.state", 32'(state), 2);
    check_val("clr_set.min", 32'(min), 0);

    // build 12:34:56 and run with num=4
    press_mode();
    press_inc(56);
    num = 32'd4;
    press_mode();
    press_mode();
    press_inc(12);
    press_mode();
    press_inc(34);
    press_mode();
    press_mode();
    check_val("pre_rst.state", 32'(state), 0);
    step(); step();
    check_time("pre_rst", 12, 34, 56);
    check_val("pre_rst.tick", 32'(tick), 0);

    // asynchronous reset mid-cycle
    rst_n = 1'b0;
    #2;
    check_time("async_rst", 0, 0, 0);
    check_val("async_rst.state", 32'(state), 0);
    check_val("async_rst.tick", 32'(tick), 0);
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check_val($sformatf("post_rst.tick%0d", e), 32'(tick), (e == 4) ? 1 : 0);
    end
    check_val("post_rst.sec", 32'(sec), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nco_timekeeper.md
# nco_timekeeper

Parametrised time-of-day counter for the counter/NCO family. A single-clock-domain NCO generates a one-cycle tick enable every `num` clock cycles, with no derived clocks. The tick advances cascaded second, minute and hour counters with carry. A small mode FSM lets the user set hour, minute and second with two debounced push-button pulses. It sits between the board clock/reset and the display/decoder blocks.

## Interface
Parameters:
- `NUM_W`, default 32: width of the NCO divide ratio and its internal counter.
- `HOUR_MOD`, default 24: hour modulus. Legal range 2..32, so `hour` is 0..HOUR_MOD-1.

Ports:
- `clk`  in  1  system clock (50 MHz on board).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `num`  in  NUM_W  divide ratio: one tick per `num` clk cycles in RUN. Values 0 and 1 both mean a tick every cycle.
- `clr`  in  1  synchronous clear of time and NCO.
- `mode_btn`  in  1  single-cycle pulse, debounced upstream; advances the mode FSM.
- `inc_btn`  in  1  single-cycle pulse, debounced upstream; increments the selected field in SET states.
- `sec`  out  6  seconds, 0..59.
- `min`  out  6  minutes, 0..59.
- `hour`  out  5  hours, 0..HOUR_MOD-1.
- `state`  out  2  mode: 0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.
- `tick`  out  1  registered pulse; high in the cycle the counters show the value produced by an NCO tick.
- `day_wrap`  out  1  registered pulse; high in the cycle the time wraps from HOUR_MOD-1:59:59 to 0:00:00.

## Operation
- Reset values of all outputs: `sec`=`min`=`hour`=0, `state`=RUN, `tick`=0, `day_wrap`=0. The internal NCO count `cnt` resets to 0.
- Priority, from highest: `rst_n`, then `clr`, then `mode_btn`, then tick or `inc_btn`.

NCO:
- NCO runs only in RUN.
- Each clk in RUN: if `cnt >= num-1`, the edge is a tick edge and `cnt` is set to 0. Otherwise `cnt` increments.
- `num-1` is evaluated so that `num`=0 behaves like `num`=1, with no underflow.
- If `num` is lowered below the current `cnt`, the next edge is a tick edge and `cnt` restarts at 0.

Cascade, on a tick edge in RUN:
- `sec` increments.
- If `sec`=59: `sec` goes to 0 and `min` increments.
- If `min`=59 as well: `min` goes to 0 and `hour` increments.
- If `hour`=HOUR_MOD-1 as well: `hour` goes to 0 and `day_wrap` is set for one cycle.
- All updates land on the same edge.
- Out-of-range values cannot arise, because every write path wraps modulo.

Mode FSM:
- Transitions on `mode_btn`: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- Entering SET_HOUR from RUN clears `cnt` to 0. `cnt` holds at 0 through all SET states.
- In SET_HOUR / SET_MIN / SET_SEC, an `inc_btn` pulse increments only the selected field, modulo HOUR_MOD, 60 or 60 respectively. There is no carry into other fields and `day_wrap` is not asserted.
- `inc_btn` in RUN is ignored.
- `mode_btn` and `inc_btn` in the same cycle: the FSM advances and the `inc_btn` is dropped.

`clr`:
- Sets `sec`, `min`, `hour` and `cnt` to 0 and `tick`, `day_wrap` to 0.
- Leaves `state` unchanged.
- Overrides a coincident tick, `inc_btn` or `mode_btn`.

## Timing
- All outputs are registered. The only asynchronous path is `rst_n`.
- Tick latency in steady RUN: a tick edge every max(num,1) cycles. With `num`=N≥1, the first tick after reset or after returning to RUN occurs on the N-th rising edge.
- `tick` and `day_wrap` are each high for exactly one cycle per event. `tick` is high in every cycle when `num`≤1.
- `inc_btn` and `mode_btn` effects are visible one cycle after the pulse's sampling edge.
- Reset asserted mid-operation: all state returns to reset values immediately. Counting resumes N edges after `rst_n` deasserts.

## Test plan
- Reset, `num`=5, run 25 cycles → `tick` pulses on edges 5, 10, 15, 20, 25; `sec` reads 1..5.
- Preload 23:59:58 via SET states, return to RUN, `num`=2 → after 4 edges `sec`=0, `min`=0, `hour`=0, with `day_wrap` high for exactly one cycle coincident with `tick`.
- In SET_MIN at `min`=59, one `inc_btn` pulse → `min`=0, `hour` unchanged, no `day_wrap`. `mode_btn` together with `inc_btn` → `state` advances and the field is unchanged.
- `num`=100 with `cnt` near 80, then change `num` to 10 → tick on the next edge, then every 10 cycles. `num`=0 → `tick` high every cycle.
- `clr` coincident with a tick at 00:00:59 → time 00:00:00, `tick` low. `clr` in SET_MIN → state stays SET_MIN.
- `rst_n` pulsed low mid-count at 12:34:56 → all outputs 0 and `state`=RUN asynchronously; first tick N edges after release. Also run with `HOUR_MOD`=12: 11:59:59 wraps to 0:00:00.
